// File: rtl/mm_stream_driver.sv
// ---------------------------------------------------------------------------
// mm_stream_driver
//   Stream initiator for the 4x4 matrix-multiply accelerator. A host loads
//   operand matrices A and B into a local word buffer through the config port.
//   A start pulse streams A then B (2*pN*pN words) out of the AXI-Stream
//   master, then collects pN*pN result words from the AXI-Stream slave into
//   the C region of the same buffer for host readback.
//
//   Optional build macro: MM_DRV_CYCLE_CNT_EN adds a saturating 16-bit busy
//   cycle counter, visible in the low half of the status word (address 48).
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   cfg_we/addr/wdata    host write port (0-15 A, 16-31 B, 32-47 C)
//   cfg_rdata            registered read data, 1-cycle latency (48 = status)
//   start                launch pulse, honoured only when not busy
//   busy, done           busy in SEND/RECV; sticky completion flag
//   sm_t*                AXI-Stream master, operands to the accelerator
//   ss_t*                AXI-Stream slave, results from the accelerator
// ---------------------------------------------------------------------------
module mm_stream_driver #(
    parameter int pDATA_WIDTH = 32,
    parameter int pN          = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [5:0]             cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    output logic [pDATA_WIDTH-1:0] cfg_rdata,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tready
);

    localparam int         NWORDS   = pN * pN;
    localparam logic [5:0] BUF_END  = 6'(3 * NWORDS);   // first non-buffer address
    localparam logic [5:0] STAT_ADR = BUF_END;
    localparam logic [4:0] TX_LAST  = 5'(2 * NWORDS - 1);
    localparam logic [3:0] RX_LAST  = 4'(NWORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] RECV = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]             state;
    logic [4:0]             tx_cnt;
    logic [3:0]             rx_cnt;
    logic [pDATA_WIDTH-1:0] mem [0:3*NWORDS-1];

    logic start_ok;
    logic host_we;
    logic sm_hs;
    logic ss_acc;

    assign busy      = (state == SEND) || (state == RECV);
    assign start_ok  = start && !busy;
    // Host writes are blocked while busy so operands cannot change mid-run.
    assign host_we   = cfg_we && !busy && (cfg_addr < BUF_END);
    assign sm_tvalid = (state == SEND);
    assign ss_tready = (state == RECV);
    assign sm_hs     = sm_tvalid && sm_tready;
    assign ss_acc    = ss_tvalid && ss_tready;

    // tx_cnt and the buffer only change on a handshake, so sm_tdata holds
    // steady through a stall.
    assign sm_tdata  = sm_tvalid ? mem[{1'b0, tx_cnt}] : '0;

    // NOTE: the word buffer has no reset; its contents are don't-care until
    // written, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[cfg_addr] <= cfg_wdata;
        end else if (ss_acc) begin
            mem[{2'b10, rx_cnt}] <= ss_tdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tx_cnt <= '0;
            rx_cnt <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                SEND: begin
                    if (sm_hs) begin
                        if (tx_cnt == TX_LAST) state  <= RECV;
                        else                   tx_cnt <= tx_cnt + 5'd1;
                    end
                end
                RECV: begin
                    if (ss_acc) begin
                        if (rx_cnt == RX_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end
                end
                default: begin  // IDLE and DONE accept a new launch
                    if (start_ok) begin
                        state  <= SEND;
                        tx_cnt <= '0;
                        rx_cnt <= '0;
                        done   <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef MM_DRV_CYCLE_CNT_EN
    logic [15:0] cyc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (start_ok) begin
            cyc_cnt <= '0;
        end else if (busy && (cyc_cnt != 16'hFFFF)) begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
`endif

    logic [pDATA_WIDTH-1:0] status;
    logic [pDATA_WIDTH-1:0] rd_next;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        status = '0;
        status[pDATA_WIDTH-1 -: 4] = {done, busy, state};
`ifdef MM_DRV_CYCLE_CNT_EN
        status[15:0] = cyc_cnt;
`endif
        rd_next = '0;
        if (cfg_addr < BUF_END)        rd_next = mem[cfg_addr];
        else if (cfg_addr == STAT_ADR) rd_next = status;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cfg_rdata <= '0;
        else     cfg_rdata <= rd_next;
    end

endmodule

// File: tb/tb_mm_stream_driver.sv
module tb_mm_stream_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        start;
    logic        busy;
    logic        done;
    logic        sm_tready;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tready;

    mm_stream_driver #(.pDATA_WIDTH(32), .pN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .sm_tready (sm_tready),
        .sm_tvalid (sm_tvalid),
        .sm_tdata  (sm_tdata),
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tready (ss_tready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] a_m     [16];
    logic [31:0] b_m     [16];
    logic [31:0] c_m     [16];
    logic [31:0] ss_vals [16];

`ifdef MM_DRV_CYCLE_CNT_EN
    localparam logic [31:0] STAT_DONE = 32'hB000_0030;
`else
    localparam logic [31:0] STAT_DONE = 32'hB000_0000;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick;
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input logic [5:0] a, output logic [31:0] d);
        cfg_addr = a;
        tick;
        d = cfg_rdata;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    function automatic logic [31:0] exp_seq(input int k);
        return (k < 16) ? a_m[k] : b_m[k-16];
    endfunction

    // Reference accelerator: C = A * B, row-major.
    task automatic model_mul;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                logic [31:0] acc;
                acc = '0;
                for (int k = 0; k < 4; k++) acc += a_m[i*4+k] * b_m[k*4+j];
                c_m[i*4+j] = acc;
            end
        end
    endtask

    // pat_mode 0: always ready; 1: ready pattern 1,0,0,1.
    // inject_at >= 0: at that handshake index, pulse start and write addr 3.
    task automatic send_phase(input int pat_mode, input int inject_at, input string tag);
        int          hs;
        int          cyc;
        logic [31:0] prev;
        logic        stalled;
        hs = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (hs < 32 && cyc < 400) begin
            sm_tready = (pat_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            check($sformatf("%s_valid%0d", tag, cyc), 32'(sm_tvalid), 32'd1);
            if (stalled) check($sformatf("%s_hold%0d", tag, cyc), sm_tdata, prev);
            if (sm_tready) check($sformatf("%s_word%0d", tag, hs), sm_tdata, exp_seq(hs));
            if (hs == inject_at && sm_tready) begin
                start     = 1'b1;
                cfg_we    = 1'b1;
                cfg_addr  = 6'd3;
                cfg_wdata = 32'h0000_DEAD;
            end
            prev    = sm_tdata;
            stalled = !sm_tready;
            if (sm_tready && sm_tvalid) hs++;
            tick;
            start  = 1'b0;
            cfg_we = 1'b0;
            cyc++;
        end
        sm_tready = 1'b0;
        check({tag, "_hs_count"}, 32'(hs), 32'd32);
        check({tag, "_sm_idle"}, 32'(sm_tvalid), 32'd0);
        check({tag, "_ss_ready"}, 32'(ss_tready), 32'd1);
    endtask

    // Source ss_vals, valid every 'period' cycles, until stop_after accepts.
    task automatic recv_phase(input int period, input int stop_after, input string tag);
        int          rx;
        int          cyc;
        logic [31:0] d;
        rx = 0; cyc = 0;
        while (rx < stop_after && cyc < 400) begin
            check($sformatf("%s_rdy%0d", tag, cyc), 32'(ss_tready), 32'd1);
            ss_tvalid = (cyc % period == 0);
            ss_tdata  = ss_vals[rx];
            if (ss_tvalid && ss_tready) begin
                rx++;
                if (rx == 16) check({tag, "_done_before_last"}, 32'(done), 32'd0);
            end
            tick;
            cyc++;
        end
        ss_tvalid = 1'b0;
        check({tag, "_rx_count"}, 32'(rx), 32'(stop_after));
        if (stop_after == 16) begin
            check({tag, "_done_after_last"}, 32'(done), 32'd1);
            check({tag, "_busy_after_last"}, 32'(busy), 32'd0);
            for (int i = 0; i < 16; i++) begin
                cfg_read(6'(32 + i), d);
                check($sformatf("%s_c%0d", tag, i), d, ss_vals[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; sm_tready = 1'b0; ss_tvalid = 1'b0; ss_tdata = '0;
        #3;
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_smv",    32'(sm_tvalid), 32'd0);
        check("rst_ssr",    32'(ss_tready), 32'd0);
        check("rst_smdata", sm_tdata,       32'd0);
        check("rst_rdata",  cfg_rdata,      32'd0);
        tick; tick;
        rst = 1'b0;

        // A = identity, B = 1..16
        for (int i = 0; i < 16; i++) begin
            a_m[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
            b_m[i] = 32'(i + 1);
            cfg_write(6'(i), a_m[i]);
            cfg_write(6'(16 + i), b_m[i]);
        end
        cfg_write(6'd50, 32'h1234_5678);
        cfg_read(6'd50, d); check("rd_addr50", d, 32'd0);
        cfg_read(6'd49, d); check("rd_addr49", d, 32'd0);
        cfg_read(6'd48, d); check("rd_stat_idle", d, 32'd0);
        cfg_read(6'd5,  d); check("rd_a5", d, 32'd1);
        cfg_read(6'd20, d); check("rd_b4", d, 32'd5);

        // Identity path, free-flowing.
        do_start;
        check("id_busy", 32'(busy), 32'd1);
        send_phase(0, -1, "id");
        model_mul;
        for (int i = 0; i < 16; i++) ss_vals[i] = c_m[i];
        recv_phase(1, 16, "id");
        cfg_read(6'd48, d); check("id_status", d, STAT_DONE);

        // Backpressure on the operand stream, bubbly results.
        for (int i = 0; i < 16; i++) ss_vals[i] = 32'(100 + i);
        do_start;
        check("bp_done_cleared", 32'(done), 32'd0);
        send_phase(1, -1, "bp");
        recv_phase(3, 16, "bub");

        // start and cfg writes during SEND must be ignored.
        do_start;
        send_phase(0, 6, "ign");
        model_mul;
        for (int i = 0; i < 16; i++) ss_vals[i] = c_m[i];
        recv_phase(1, 16, "ign");
        cfg_read(6'd3, d); check("ign_a3", d, 32'd0);

        // Reset mid-RECV aborts asynchronously.
        do_start;
        send_phase(0, -1, "rs");
        recv_phase(1, 5, "rs");
        check("rs_busy_pre", 32'(busy), 32'd1);
        ss_tvalid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rs_smv",  32'(sm_tvalid), 32'd0);
        check("rs_ssr",  32'(ss_tready), 32'd0);
        check("rs_busy", 32'(busy),      32'd0);
        check("rs_done", 32'(done),      32'd0);
        ss_tvalid = 1'b0;
        tick;
        rst = 1'b0;
        tick;

        // Same-cycle write and start: SEND uses the new B[0].
        cfg_we = 1'b1; cfg_addr = 6'd16; cfg_wdata = 32'd7; start = 1'b1;
        tick;
        cfg_we = 1'b0; start = 1'b0;
        b_m[0] = 32'd7;
        send_phase(0, -1, "rs2");
        model_mul;
        for (int i = 0; i < 16; i++) ss_vals[i] = c_m[i];
        recv_phase(1, 16, "rs2");
        cfg_read(6'd48, d); check("rs2_status", d, STAT_DONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
